// File: rtl/wb_reg_bank.sv
// Wishbone (pipelined) slave register bank: single outstanding single-beat transaction,
// programmable wait states before ack, registers exposed as a flattened bus.
module wb_reg_bank #(
   parameter int BYTES       = 1,
   parameter int ADDR_BITS   = 8,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                            clk,
   input  logic                            sreset,
   input  logic                            wb_cyc,
   input  logic                            wb_stb,
   input  logic                            wb_we,
   input  logic [ADDR_BITS-1:0]            wb_addr,
   input  logic [BYTES*8-1:0]              wb_dat_m2s,
   output logic [BYTES*8-1:0]              wb_dat_s2m,
   output logic                            wb_ack,
   output logic                            wb_stall,
   output logic [NUM_REGS*BYTES*8-1:0]     regs_o,
   output logic                            wr_pulse_o,
   output logic [ADDR_BITS-1:0]            wr_addr_o
);

   localparam int W        = BYTES * 8;
   localparam int IDX_BITS = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_BITS:0] NUM_REGS_L = (ADDR_BITS + 1)'(NUM_REGS);
   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t                state_reg, state_next;
   logic [3:0]            cnt_reg, cnt_next;
   logic                  accept;
   logic [W-1:0]          mem_reg [NUM_REGS];
   logic [W-1:0]          rd_data_reg;
   logic                  wr_pulse_reg;
   logic [ADDR_BITS-1:0]  wr_addr_reg;
   logic                  in_range;
   logic [IDX_BITS-1:0]   idx;

   assign in_range = ({1'b0, wb_addr} < NUM_REGS_L);
   assign idx      = wb_addr[IDX_BITS-1:0];

   // Dropping cyc aborts from any state; the request is only seen in IDLE.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      accept     = 1'b0;
      if (!wb_cyc) begin
         state_next = S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (wb_stb) begin
                  accept = 1'b1;
                  if (WAIT_STATES > 0) begin
                     state_next = S_WAIT;
                     cnt_next   = WS_LOAD;
                  end else begin
                     state_next = S_ACK;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_reg == 4'd0) state_next = S_ACK;
               else                 cnt_next   = cnt_reg - 4'd1;
            end
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (sreset) begin
         state_reg    <= S_IDLE;
         cnt_reg      <= 4'd0;
         rd_data_reg  <= '0;
         wr_pulse_reg <= 1'b0;
         wr_addr_reg  <= '0;
         for (int i = 0; i < NUM_REGS; i++) mem_reg[i] <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         wr_pulse_reg <= 1'b0;
         if (accept) begin
            if (wb_we) begin
               // Out-of-range writes are acked but leave no trace.
               if (in_range) begin
                  mem_reg[idx] <= wb_dat_m2s;
                  wr_pulse_reg <= 1'b1;
                  wr_addr_reg  <= wb_addr;
               end
            end else begin
               rd_data_reg <= in_range ? mem_reg[idx] : '0;
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
         assign regs_o[gi*W +: W] = mem_reg[gi];
      end
   endgenerate

   assign wb_dat_s2m = rd_data_reg;
   assign wb_ack     = (state_reg == S_ACK) && wb_cyc;
   assign wb_stall   = (state_reg != S_IDLE);
   assign wr_pulse_o = wr_pulse_reg;
   assign wr_addr_o  = wr_addr_reg;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Bench for wb_reg_bank: table-driven single-cycle transactions on a zero-wait instance,
// plus hand sequences for wait states, stall, abort and mid-transaction reset.
module tb_wb_reg_bank;

   logic          clk = 1'b0;
   logic          sreset;
   logic          stb, we;
   logic [7:0]    addr, dat;
   logic          cyc0, cyc2, cyc3;
   logic          ack0, ack2, ack3, stall0, stall2, stall3;
   logic          pulse0, pulse2, pulse3;
   logic [7:0]    rd0, rd2, rd3, waddr0, waddr2, waddr3;
   logic [127:0]  regs0, regs2, regs3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_reg_bank #(.BYTES(1), .ADDR_BITS(8), .NUM_REGS(16), .WAIT_STATES(0)) d0 (
      .clk(clk), .sreset(sreset), .wb_cyc(cyc0), .wb_stb(stb), .wb_we(we), .wb_addr(addr),
      .wb_dat_m2s(dat), .wb_dat_s2m(rd0), .wb_ack(ack0), .wb_stall(stall0),
      .regs_o(regs0), .wr_pulse_o(pulse0), .wr_addr_o(waddr0));

   wb_reg_bank #(.BYTES(1), .ADDR_BITS(8), .NUM_REGS(16), .WAIT_STATES(2)) d2 (
      .clk(clk), .sreset(sreset), .wb_cyc(cyc2), .wb_stb(stb), .wb_we(we), .wb_addr(addr),
      .wb_dat_m2s(dat), .wb_dat_s2m(rd2), .wb_ack(ack2), .wb_stall(stall2),
      .regs_o(regs2), .wr_pulse_o(pulse2), .wr_addr_o(waddr2));

   wb_reg_bank #(.BYTES(1), .ADDR_BITS(8), .NUM_REGS(16), .WAIT_STATES(3)) d3 (
      .clk(clk), .sreset(sreset), .wb_cyc(cyc3), .wb_stb(stb), .wb_we(we), .wb_addr(addr),
      .wb_dat_m2s(dat), .wb_dat_s2m(rd3), .wb_ack(ack3), .wb_stall(stall3),
      .regs_o(regs3), .wr_pulse_o(pulse3), .wr_addr_o(waddr3));

   typedef struct {
      logic          we;
      logic [7:0]    addr;
      logic [7:0]    wdata;
      logic [7:0]    exp_rdata;
      logic          exp_pulse;
      logic [127:0]  exp_regs;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{1'b1, 8'h03, 8'hA5, 8'h00, 1'b1, 128'h0000_0000_0000_0000_0000_0000_A500_0000};
      vecs[1] = '{1'b0, 8'h03, 8'h00, 8'hA5, 1'b0, 128'h0000_0000_0000_0000_0000_0000_A500_0000};
      vecs[2] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 128'h0000_0000_0000_0000_0000_0000_A500_0000};
      vecs[3] = '{1'b1, 8'h20, 8'hFF, 8'h00, 1'b0, 128'h0000_0000_0000_0000_0000_0000_A500_0000};
      vecs[4] = '{1'b0, 8'h20, 8'h00, 8'h00, 1'b0, 128'h0000_0000_0000_0000_0000_0000_A500_0000};
      vecs[5] = '{1'b1, 8'h0F, 8'h3C, 8'h00, 1'b1, 128'h3C00_0000_0000_0000_0000_0000_A500_0000};
      vecs[6] = '{1'b0, 8'h0F, 8'h00, 8'h3C, 1'b0, 128'h3C00_0000_0000_0000_0000_0000_A500_0000};
      vecs[7] = '{1'b1, 8'h03, 8'h01, 8'h00, 1'b1, 128'h3C00_0000_0000_0000_0000_0000_0100_0000};
      vecs[8] = '{1'b0, 8'h03, 8'h00, 8'h01, 1'b0, 128'h3C00_0000_0000_0000_0000_0000_0100_0000};

      sreset = 1'b1; stb = 1'b0; we = 1'b0; addr = 8'h00; dat = 8'h00;
      cyc0 = 1'b0; cyc2 = 1'b0; cyc3 = 1'b0;
      tick(); tick();
      sreset = 1'b0;
      chk("rst_ack", ack0, 0);
      chk("rst_stall", stall0, 0);
      chk("rst_regs", regs0, 0);
      chk("rst_rdata", rd0, 0);
      chk("rst_pulse", pulse0, 0);
      chk("rst_waddr", waddr0, 0);

      // Zero-wait instance: each transaction acks on the cycle after acceptance.
      for (int i = 0; i < NV; i++) begin
         cyc0 = 1'b1; stb = 1'b1; we = vecs[i].we; addr = vecs[i].addr; dat = vecs[i].wdata;
         tick();
         chk("v_ack", ack0, 1);
         chk("v_stall", stall0, 1);
         chk("v_pulse", pulse0, vecs[i].exp_pulse);
         if (vecs[i].exp_pulse) chk("v_waddr", waddr0, vecs[i].addr);
         if (!vecs[i].we) chk("v_rdata", rd0, vecs[i].exp_rdata);
         chk("v_regs", regs0, vecs[i].exp_regs);
         cyc0 = 1'b0; stb = 1'b0;
         tick();
         chk("v_ack_off", ack0, 0);
         chk("v_stall_off", stall0, 0);
         chk("v_pulse_off", pulse0, 0);
         $display("txn %0d: we=%0b addr=%02h wdata=%02h rdata=%02h pulse=%0b", i, vecs[i].we,
                  vecs[i].addr, vecs[i].wdata, rd0, vecs[i].exp_pulse);
      end

      // stb without cyc must be ignored.
      stb = 1'b1; we = 1'b1; addr = 8'h04; dat = 8'h99;
      tick();
      chk("nocyc_stall", stall0, 0);
      chk("nocyc_pulse", pulse0, 0);
      chk("nocyc_regs", regs0, 128'h3C00_0000_0000_0000_0000_0000_0100_0000);
      stb = 1'b0;
      tick();

      // Three wait states: write accepted at N acks at N+4; a stb raised at N+2 is taken at N+5.
      cyc3 = 1'b1; stb = 1'b1; we = 1'b1; addr = 8'h01; dat = 8'h5A;
      for (int c = 1; c <= 10; c++) begin
         tick();
         chk("ws3_ack", ack3, (c == 4 || c == 9));
         chk("ws3_stall", stall3, !(c == 5 || c == 10));
         if (c == 1) begin
            chk("ws3_pulse", pulse3, 1);
            chk("ws3_waddr", waddr3, 8'h01);
            chk("ws3_reg1", regs3[15:8], 8'h5A);
            stb = 1'b0;
         end
         if (c == 2) begin
            chk("ws3_pulse_off", pulse3, 0);
            stb = 1'b1; we = 1'b0; addr = 8'h01; dat = 8'h00;
         end
         if (c == 6) stb = 1'b0;
         if (c == 9) chk("ws3_rdata", rd3, 8'h5A);
      end
      $display("txn ws3: write 5A to addr 1 then read back %02h", rd3);
      cyc3 = 1'b0;
      tick();

      // Abort: cyc dropped at N+2 after a write accept; no ack, write still lands.
      cyc3 = 1'b1; stb = 1'b1; we = 1'b1; addr = 8'h02; dat = 8'h11;
      for (int c = 1; c <= 6; c++) begin
         tick();
         chk("abort_ack", ack3, 0);
         chk("abort_stall", stall3, (c < 3));
         if (c == 1) begin
            chk("abort_pulse", pulse3, 1);
            stb = 1'b0;
         end
         if (c == 2) cyc3 = 1'b0;
      end
      cyc3 = 1'b1; stb = 1'b1; we = 1'b0; addr = 8'h02;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 1) stb = 1'b0;
         chk("abort_rd_ack", ack3, (c == 4));
      end
      chk("abort_rdata", rd3, 8'h11);
      $display("txn abort: addr 2 reads %02h after aborted write", rd3);
      cyc3 = 1'b0;
      tick();

      // Two wait states: reset one cycle after a read is accepted.
      cyc2 = 1'b1; stb = 1'b1; we = 1'b1; addr = 8'h05; dat = 8'h77;
      tick();
      stb = 1'b0;
      tick(); tick();
      chk("ws2_wr_ack", ack2, 1);
      tick();
      stb = 1'b1; we = 1'b0; addr = 8'h05;
      tick();
      chk("ws2_rd_load", rd2, 8'h77);
      stb = 1'b0; sreset = 1'b1;
      tick();
      sreset = 1'b0;
      chk("mrst_ack", ack2, 0);
      chk("mrst_stall", stall2, 0);
      chk("mrst_rdata", rd2, 0);
      chk("mrst_regs", regs2, 0);
      chk("mrst_pulse", pulse2, 0);
      chk("mrst_waddr", waddr2, 0);
      chk("mrst_regs_d0", regs0, 0);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("mrst_no_ack", ack2, 0);
      end
      stb = 1'b1; we = 1'b0; addr = 8'h05;
      tick();
      stb = 1'b0;
      tick(); tick();
      chk("post_rd_ack", ack2, 1);
      chk("post_rdata", rd2, 0);
      tick();
      stb = 1'b1; we = 1'b1; addr = 8'h05; dat = 8'h42;
      tick();
      stb = 1'b0;
      chk("post_pulse", pulse2, 1);
      chk("post_waddr", waddr2, 8'h05);
      chk("post_reg5", regs2[47:40], 8'h42);
      tick(); tick();
      chk("post_wr_ack", ack2, 1);
      $display("txn reset: post-reset read %02h, write 42 to addr 5", rd2);
      cyc2 = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
